// File: rtl/vga_scanout.sv
// VGA 640x480@60 scan-out: sequential frame-buffer reads, syncs/blank delayed to line up with read data.
// Optional colour-bar test pattern (input Test_Mode) when VGA_SCANOUT_TESTPAT_EN is defined.
//
// state | meaning
// IDLE  | counters held at 0, syncs high, blanked; leaves on a pixel tick with Fb_Ready
// SCAN  | raster running; back to IDLE only at end of frame with Fb_Ready low
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int RD_LAT   = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Pix_En,
  input  logic        Fb_Ready,
`ifdef VGA_SCANOUT_TESTPAT_EN
  input  logic        Test_Mode,
`endif
  output logic        Fb_Rd,
  output logic [18:0] Fb_Addr,
  input  logic [7:0]  Fb_Data,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_Blank_N,
  output logic        Frame_Start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT     = 10'(V_ACTIVE);
  localparam logic [9:0]  HS_BEG    = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  VS_BEG    = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [18:0] ADDR_LAST = 19'(H_ACTIVE * V_ACTIVE - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t      state, state_nxt;
  logic [9:0]  h, v;
  logic [18:0] addr;
  logic        h_last, v_last, frame_end;
  logic        active, hs_n, vs_n;
  logic [RD_LAT-1:0] act_d, hs_d, vs_d;
  logic [7:0]  pix_r, pix_g, pix_b;

  assign h_last    = (h == H_LAST);
  assign v_last    = (v == V_LAST);
  assign frame_end = h_last && v_last;
  assign active    = (state == SCAN) && (h < H_ACT) && (v < V_ACT);
  assign hs_n      = !((h >= HS_BEG) && (h <= HS_END));
  assign vs_n      = !((v >= VS_BEG) && (v <= VS_END));

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (Pix_En && Fb_Ready) state_nxt = SCAN;
      SCAN: if (Pix_En && frame_end && !Fb_Ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address advances only past active pixels and saturates at the last one
  always_ff @(posedge Clk) begin
    if (Reset) begin
      h    <= '0;
      v    <= '0;
      addr <= '0;
    end else if (Pix_En) begin
      if (state != SCAN) begin
        h    <= '0;
        v    <= '0;
        addr <= '0;
      end else begin
        if (h_last) begin
          h <= '0;
          v <= v_last ? 10'd0 : v + 10'd1;
        end else begin
          h <= h + 10'd1;
        end
        if (frame_end)
          addr <= '0;
        else if (active && (addr != ADDR_LAST))
          addr <= addr + 19'd1;
      end
    end
  end

  assign Fb_Addr     = addr;
  assign Frame_Start = Pix_En && (state == SCAN) && (h == 10'd0) && (v == 10'd0);

`ifdef VGA_SCANOUT_TESTPAT_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0] bar_raw;
  logic [2:0] bar_d [RD_LAT];

  always_comb begin
    bar_raw = '0;
    for (int k = 1; k < 8; k++)
      if (h >= 10'(k * BAR_W)) bar_raw = 3'(k);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < RD_LAT; i++) bar_d[i] <= '0;
    end else if (Pix_En) begin
      bar_d[0] <= bar_raw;
      for (int i = 1; i < RD_LAT; i++) bar_d[i] <= bar_d[i-1];
    end
  end

  assign Fb_Rd = active && !Test_Mode;
`else
  assign Fb_Rd = active;
`endif

  always_comb begin
    pix_r = {Fb_Data[7:5], Fb_Data[7:5], Fb_Data[7:6]};
    pix_g = {Fb_Data[4:2], Fb_Data[4:2], Fb_Data[4:3]};
    pix_b = {4{Fb_Data[1:0]}};
`ifdef VGA_SCANOUT_TESTPAT_EN
    if (Test_Mode) begin
      pix_r = {8{bar_d[RD_LAT-1][2]}};
      pix_g = {8{bar_d[RD_LAT-1][1]}};
      pix_b = {8{bar_d[RD_LAT-1][0]}};
    end
`endif
  end

  // Sync pipelines idle high so reset never produces a spurious sync pulse
  always_ff @(posedge Clk) begin
    if (Reset) begin
      act_d       <= '0;
      hs_d        <= '1;
      vs_d        <= '1;
      VGA_Blank_N <= 1'b0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else if (Pix_En) begin
      act_d[0] <= active;
      hs_d[0]  <= hs_n;
      vs_d[0]  <= vs_n;
      for (int i = 1; i < RD_LAT; i++) begin
        act_d[i] <= act_d[i-1];
        hs_d[i]  <= hs_d[i-1];
        vs_d[i]  <= vs_d[i-1];
      end
      VGA_Blank_N <= act_d[RD_LAT-1];
      VGA_HS      <= hs_d[RD_LAT-1];
      VGA_VS      <= vs_d[RD_LAT-1];
      VGA_R       <= act_d[RD_LAT-1] ? pix_r : 8'd0;
      VGA_G       <= act_d[RD_LAT-1] ? pix_g : 8'd0;
      VGA_B       <= act_d[RD_LAT-1] ? pix_b : 8'd0;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: full-size instance for first-lines timing literals,
// reduced-raster instance checked every cycle against a frame-arithmetic model.
module tb_vga_scanout;

  localparam int SHA = 16, SHF = 4, SHS = 6, SHB = 4;
  localparam int SVA = 8,  SVF = 2, SVS = 2, SVB = 3;
  localparam int SLAT = 3;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVT = SVA + SVF + SVS + SVB;
  localparam int SFRAME = SHT * SVT;
  localparam int FLAT = 2;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        rst_s = 1'b1, pen_s = 1'b0, rdy_s = 1'b0;
  logic        rd_s, hs_s, vs_s, bn_s, fs_s;
  logic [18:0] addr_s;
  logic [7:0]  data_s, r_s, g_s, b_s;

  logic        rst_f = 1'b1, pen_f = 1'b0, rdy_f = 1'b0;
  logic        rd_f, hs_f, vs_f, bn_f, fs_f;
  logic [18:0] addr_f;
  logic [7:0]  data_f, r_f, g_f, b_f;

`ifdef VGA_SCANOUT_TESTPAT_EN
  logic tm = 1'b0;
`endif

  vga_scanout #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .RD_LAT(SLAT)
  ) u_small (
    .Clk(Clk), .Reset(rst_s), .Pix_En(pen_s), .Fb_Ready(rdy_s),
`ifdef VGA_SCANOUT_TESTPAT_EN
    .Test_Mode(tm),
`endif
    .Fb_Rd(rd_s), .Fb_Addr(addr_s), .Fb_Data(data_s),
    .VGA_R(r_s), .VGA_G(g_s), .VGA_B(b_s), .VGA_HS(hs_s), .VGA_VS(vs_s),
    .VGA_Blank_N(bn_s), .Frame_Start(fs_s)
  );

  vga_scanout #(.RD_LAT(FLAT)) u_full (
    .Clk(Clk), .Reset(rst_f), .Pix_En(pen_f), .Fb_Ready(rdy_f),
`ifdef VGA_SCANOUT_TESTPAT_EN
    .Test_Mode(tm),
`endif
    .Fb_Rd(rd_f), .Fb_Addr(addr_f), .Fb_Data(data_f),
    .VGA_R(r_f), .VGA_G(g_f), .VGA_B(b_f), .VGA_HS(hs_f), .VGA_VS(vs_f),
    .VGA_Blank_N(bn_f), .Frame_Start(fs_f)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mem_s(input logic [18:0] a);
    return 8'(a * 37 + 11);
  endfunction

  function automatic logic [23:0] expand(input logic [7:0] d);
    return {d[7:5], d[7:5], d[7:6], d[4:2], d[4:2], d[4:3], {4{d[1:0]}}};
  endfunction

  // Frame buffers: read data returns a fixed number of pixel ticks after the address
  logic [7:0] ms [SLAT] = '{default: 8'h00};
  logic [7:0] mf [FLAT] = '{default: 8'h00};
  always @(posedge Clk) begin
    if (pen_s) begin
      ms[0] <= mem_s(addr_s);
      for (int i = 1; i < SLAT; i++) ms[i] <= ms[i-1];
    end
    if (pen_f) begin
      mf[0] <= addr_f[7:0];
      for (int i = 1; i < FLAT; i++) mf[i] <= mf[i-1];
    end
  end
  assign data_s = ms[SLAT-1];
  assign data_f = mf[FLAT-1];

  // Model: frame position k of the next tick, plus the raw pixels of the last SLAT ticks
  typedef struct {
    logic act, hs, vs;
    logic [7:0] d;
  } raw_t;

  raw_t q[$];
  raw_t mr, mo;
  bit   m_scan = 1'b0, m_ok = 1'b0;
  int   m_k = 0, st = 0;
  logic [7:0] e_r, e_g, e_b;
  logic e_hs, e_vs, e_bn;

  function automatic raw_t raw_at(input bit scan, input int k);
    raw_t r;
    int h, v;
    h = k % SHT;
    v = k / SHT;
    r.act = scan && (h < SHA) && (v < SVA);
    r.hs  = !(scan && (h >= SHA + SHF) && (h < SHA + SHF + SHS));
    r.vs  = !(scan && (v >= SVA + SVF) && (v < SVA + SVF + SVS));
    r.d   = mem_s(19'(v * SHA + h));
    return r;
  endfunction

  always @(posedge Clk) begin
    if (rst_s) begin
      q.delete();
      for (int i = 0; i < SLAT; i++) q.push_back(raw_at(1'b0, 0));
      m_scan = 1'b0; m_k = 0; m_ok = 1'b1;
      e_r = 8'h00; e_g = 8'h00; e_b = 8'h00;
      e_hs = 1'b1; e_vs = 1'b1; e_bn = 1'b0;
    end else if (pen_s) begin
      mr = raw_at(m_scan, m_k);
      q.push_back(mr);
      mo = q.pop_front();
      e_bn = mo.act; e_hs = mo.hs; e_vs = mo.vs;
      {e_r, e_g, e_b} = mo.act ? expand(mo.d) : 24'h0;
      st++;
      if (m_scan) begin
        if (m_k == SFRAME - 1) begin
          m_k = 0;
          if (!rdy_s) m_scan = 1'b0;
        end else begin
          m_k++;
        end
      end else if (rdy_s) begin
        m_scan = 1'b1;
        m_k = 0;
      end
    end
  end

  int c_h, c_v, c_a;
  int fs_tot = 0, rd_tot = 0, vs_lo_tot = 0, bn_tot = 0, max_addr = 0;
  int last_fs_st = -1, last_gap = 0;

  always @(negedge Clk) begin
    if (m_ok) begin
      c_h = m_k % SHT;
      c_v = m_k / SHT;
      c_a = c_v * SHA + ((c_h < SHA) ? c_h : SHA);
      if (c_a > SHA * SVA - 1) c_a = SHA * SVA - 1;
      if (!m_scan) c_a = 0;
      chk("s_r", r_s, e_r);
      chk("s_g", g_s, e_g);
      chk("s_b", b_s, e_b);
      chk("s_hs", hs_s, e_hs);
      chk("s_vs", vs_s, e_vs);
      chk("s_blank_n", bn_s, e_bn);
      chk("s_fb_rd", rd_s, m_scan && (c_h < SHA) && (c_v < SVA));
      chk("s_fb_addr", addr_s, c_a);
      chk("s_frame_start", fs_s, m_scan && (m_k == 0) && pen_s);
      if (pen_s) begin
        fs_tot += fs_s;
        rd_tot += rd_s;
        vs_lo_tot += !vs_s;
        bn_tot += bn_s;
        if (rd_s && (int'(addr_s) > max_addr)) max_addr = int'(addr_s);
        if (fs_s) begin
          if (last_fs_st >= 0) last_gap = st - last_fs_st;
          last_fs_st = st;
        end
      end
    end
  end

  task automatic pix_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      pen_s = 1'b1;
      @(posedge Clk); #1;
      pen_s = 1'b0;
      @(posedge Clk); #1;
    end
  endtask

  task automatic wait_pos(input string name, input int k);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2 * SFRAME; i++) begin
      if (m_scan && m_k == k) begin
        ok = 1'b1;
        break;
      end
      pix_ticks(1);
    end
    chk(name, ok, 1'b1);
  endtask

  int fcnt = 0, fs_at = -1, hs_lo = 0, hs_first = -1, vs_lo = 0, bn_hi = 0;
  int s_fs, s_rd, s_vs, s_bn;

  initial begin
    // Full-size raster, one pixel tick per Clk
    rst_f = 1'b1; rdy_f = 1'b1; pen_f = 1'b1;
    repeat (3) @(posedge Clk);
    #1 rst_f = 1'b0;
    for (int n = 0; n < 1600; n++) begin
      @(negedge Clk);
      if (fs_f) begin
        fcnt++;
        if (fs_at < 0) fs_at = n;
      end
      if (!hs_f) begin
        hs_lo++;
        if (hs_first < 0) hs_first = n;
      end
      if (!vs_f) vs_lo++;
      if (bn_f) bn_hi++;
      if (n == 0) begin
        chk("f_reset_hs", hs_f, 1'b1);
        chk("f_reset_blank_n", bn_f, 1'b0);
        chk("f_reset_fb_rd", rd_f, 1'b0);
      end
      if (n == 701) chk("f_addr_hblank", addr_f, 640);
      if (n == 801) chk("f_addr_line1", addr_f, 640);
      if (n == 806) begin
        chk("f_rd_x5y1", rd_f, 1'b1);
        chk("f_addr_x5y1", addr_f, 645);
      end
      if (n == 808) chk("f_data_x5y1", data_f, 8'h85);
      if (n == 809) begin
        chk("f_r_x5y1", r_f, 8'h92);
        chk("f_g_x5y1", g_f, 8'h24);
        chk("f_b_x5y1", b_f, 8'h55);
        chk("f_blank_n_x5y1", bn_f, 1'b1);
      end
    end
    chk("f_frame_start_at", fs_at, 1);
    chk("f_frame_start_cnt", fcnt, 1);
    chk("f_hs_fall_offset", hs_first - 2, 656 + FLAT);
    chk("f_hs_low_2lines", hs_lo, 192);
    chk("f_vs_low", vs_lo, 0);
    chk("f_blank_n_2lines", bn_hi, 1280);
    pen_f = 1'b0; rst_f = 1'b1;

    // Reduced raster, pixel tick every 2nd Clk: idle with Fb_Ready low
    rst_s = 1'b1; rdy_s = 1'b0;
    pix_ticks(3);
    rst_s = 1'b0;
    s_fs = fs_tot; s_rd = rd_tot;
    pix_ticks(1000);
    chk("s_idle_frame_start", fs_tot - s_fs, 0);
    chk("s_idle_fb_rd", rd_tot - s_rd, 0);

    // Three back-to-back frames
    rdy_s = 1'b1;
    s_fs = fs_tot;
    pix_ticks(3 * SFRAME);
    chk("s_frames_started", fs_tot - s_fs, 3);
    chk("s_frame_gap", last_gap, SFRAME);
    chk("s_max_addr", max_addr, SHA * SVA - 1);

    // Drop Fb_Ready at row 5: frame must complete then idle
    wait_pos("s_wait_row5", 5 * SHT);
    rdy_s = 1'b0;
    s_fs = fs_tot; s_vs = vs_lo_tot; s_bn = bn_tot;
    pix_ticks(2 * SFRAME);
    chk("s_drop_vs_low", vs_lo_tot - s_vs, SVS * SHT);
    chk("s_drop_blank_n", bn_tot - s_bn, (SVA - 5) * SHA);
    chk("s_drop_frame_start", fs_tot - s_fs, 0);

    // Reset in the middle of an active row
    rdy_s = 1'b1;
    wait_pos("s_wait_row4", 4 * SHT + 7);
    chk("s_pre_reset_blank_n", bn_s, 1'b1);
    rst_s = 1'b1;
    @(posedge Clk); #1;
    rst_s = 1'b0;
    @(negedge Clk);
    chk("s_mid_reset_hs", hs_s, 1'b1);
    chk("s_mid_reset_vs", vs_s, 1'b1);
    chk("s_mid_reset_blank_n", bn_s, 1'b0);
    chk("s_mid_reset_rgb", {r_s, g_s, b_s}, 24'h0);
    chk("s_mid_reset_fb_rd", rd_s, 1'b0);
    chk("s_mid_reset_addr", addr_s, 0);
    pix_ticks(SFRAME + 20);
    chk("s_restart_gap", last_gap, SFRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
